// File: rtl/seq_arith_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seq_arith_unit                                                |
// | Purpose  : Handshaked unsigned add/sub/mul/div; iterative mul and div.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module seq_arith_unit #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               flag
);

  localparam int              c_CW     = $clog2(WIDTH + 1);
  localparam logic [c_CW-1:0] c_LAST   = c_CW'(WIDTH - 1);
  localparam logic [1:0]      c_OP_ADD = 2'd0;
  localparam logic [1:0]      c_OP_SUB = 2'd1;
  localparam logic [1:0]      c_OP_MUL = 2'd2;
  localparam logic [1:0]      c_OP_DIV = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [1:0]           r_op;
  logic [WIDTH-1:0]     r_b;
  logic [2*WIDTH-1:0]   r_acc;
  logic [c_CW-1:0]      r_cnt;

  logic                 w_accept;
  logic                 w_iterate;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_diff;
  logic [WIDTH:0]       w_mul_hi;
  logic [2*WIDTH-1:0]   w_mul_acc;
  logic [WIDTH:0]       w_shift;
  logic                 w_qbit;
  logic [WIDTH-1:0]     w_rem;
  logic [2*WIDTH-1:0]   w_div_acc;
  logic [2*WIDTH-1:0]   w_acc_next;

  assign w_accept  = start && (r_state != S_CALC);
  assign w_iterate = (op == c_OP_MUL) || ((op == c_OP_DIV) && (y != '0));

  assign w_sum  = {1'b0, x} + {1'b0, y};
  assign w_diff = {1'b0, x} - {1'b0, y};

  // Multiply: r_acc = {partial product high half, remaining multiplier bits}.
  assign w_mul_hi  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mul_acc = {w_mul_hi, r_acc[WIDTH-1:1]};

  // Divide: r_acc = {partial remainder, dividend bits shifting into quotient}.
  // The restored remainder is always below the divisor, so WIDTH bits suffice.
  assign w_shift   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_qbit    = (w_shift >= {1'b0, r_b});
  assign w_rem     = w_shift[WIDTH-1:0] - (w_qbit ? r_b : '0);
  assign w_div_acc = {w_rem, r_acc[WIDTH-2:0], w_qbit};

  assign w_acc_next = (r_op == c_OP_MUL) ? w_mul_acc : w_div_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = S_IDLE;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE, S_FIN: begin
        done = (r_state == S_FIN);
        if (start) begin
          w_state_next = w_iterate ? S_CALC : S_FIN;
        end
      end
      S_CALC: begin
        busy         = 1'b1;
        w_state_next = (r_cnt == c_LAST) ? S_FIN : S_CALC;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op   <= c_OP_ADD;
      r_b    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      result <= '0;
      flag   <= 1'b0;
    end else if (w_accept) begin
      r_op  <= op;
      r_cnt <= '0;
      case (op)
        c_OP_ADD: begin
          result <= {{(WIDTH-1){1'b0}}, w_sum};
          flag   <= w_sum[WIDTH];
        end
        c_OP_SUB: begin
          result <= {{WIDTH{1'b0}}, w_diff[WIDTH-1:0]};
          flag   <= w_diff[WIDTH];
        end
        c_OP_MUL: begin
          r_b   <= x;
          r_acc <= {{WIDTH{1'b0}}, y};
        end
        default: begin
          if (y == '0) begin
            result <= {x, {WIDTH{1'b1}}};
            flag   <= 1'b1;
          end else begin
            r_b   <= y;
            r_acc <= {{WIDTH{1'b0}}, x};
          end
        end
      endcase
    end else if (r_state == S_CALC) begin
      r_acc <= w_acc_next;
      if (r_cnt == c_LAST) begin
        result <= w_acc_next;
        flag   <= (r_op == c_OP_MUL) && (|w_acc_next[2*WIDTH-1:WIDTH]);
      end else begin
        r_cnt <= r_cnt + c_CW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_arith_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_seq_arith_unit                                             |
// | Purpose  : Directed and randomized checks of seq_arith_unit, W=4 and 8.  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_seq_arith_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start4 = 1'b0, start8 = 1'b0;
  logic [1:0]  op4 = 2'd0, op8 = 2'd0;
  logic [3:0]  x4 = '0, y4 = '0;
  logic [7:0]  x8 = '0, y8 = '0;
  logic        busy4, done4, flag4, busy8, done8, flag8;
  logic [7:0]  result4;
  logic [15:0] result8;

  int          n_tests = 0;
  int          n_fail  = 0;
  longint      last_r4 = 0, last_r8 = 0;
  logic        last_f4 = 1'b0, last_f8 = 1'b0;

  always #5 clk = ~clk;

  seq_arith_unit #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .op(op4), .x(x4), .y(y4),
    .busy(busy4), .done(done4), .result(result4), .flag(flag4)
  );

  seq_arith_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .x(x8), .y(y8),
    .busy(busy8), .done(done8), .result(result8), .flag(flag8)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic obs_busy(input bit w8);
    return w8 ? busy8 : busy4;
  endfunction
  function automatic logic obs_done(input bit w8);
    return w8 ? done8 : done4;
  endfunction
  function automatic logic obs_flag(input bit w8);
    return w8 ? flag8 : flag4;
  endfunction
  function automatic longint obs_result(input bit w8);
    return w8 ? longint'(result8) : longint'(result4);
  endfunction

  task automatic drive(input bit w8, input logic st, input logic [1:0] o,
                       input logic [7:0] a, input logic [7:0] b);
    if (w8) begin
      start8 = st; op8 = o; x8 = a; y8 = b;
    end else begin
      start4 = st; op4 = o; x4 = a[3:0]; y4 = b[3:0];
    end
  endtask

  // Arithmetic reference: what the unit should report and after how many cycles.
  function automatic void model(input int w, input logic [1:0] o, input longint a,
                                input longint b, output longint r, output logic f,
                                output int lat);
    longint m = longint'(1) << w;
    lat = 1;
    case (o)
      2'd0: begin r = a + b; f = (r >= m); end
      2'd1: begin r = (a - b + m) % m; f = (b > a); end
      2'd2: begin r = a * b; f = (r >= m); lat = w + 1; end
      default: begin
        if (b == 0) begin
          r = a * m + (m - 1); f = 1'b1;
        end else begin
          r = (a % b) * m + (a / b); f = 1'b0; lat = w + 1;
        end
      end
    endcase
  endfunction

  // Called right after the acceptance edge; returns at the done-cycle negedge
  // with start untouched so the caller may chain the next operation.
  task automatic wait_result(input bit w8, input longint er, input logic ef,
                             input int lat, input string tag, input bit poke);
    int     k = 1;
    longint pr = w8 ? last_r8 : last_r4;
    logic   pf = w8 ? last_f8 : last_f4;
    @(negedge clk);
    while (!obs_done(w8) && k <= lat + 1) begin
      check({tag, "_busy"}, longint'(obs_busy(w8)), longint'(k < lat));
      check({tag, "_held"}, obs_result(w8), pr);
      check({tag, "_heldf"}, longint'(obs_flag(w8)), longint'(pf));
      drive(w8, poke && (k == 2), 2'($urandom_range(0, 3)),
            8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      @(negedge clk);
      k++;
    end
    check({tag, "_done"}, longint'(obs_done(w8)), 1);
    check({tag, "_lat"}, longint'(k), longint'(lat));
    check({tag, "_busy_at_done"}, longint'(obs_busy(w8)), 0);
    check({tag, "_res"}, obs_result(w8), er);
    check({tag, "_flag"}, longint'(obs_flag(w8)), longint'(ef));
    if (w8) begin last_r8 = er; last_f8 = ef; end
    else begin last_r4 = er; last_f4 = ef; end
  endtask

  task automatic dir4(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                      input longint er, input logic ef, input int lat,
                      input string tag, input bit poke);
    drive(1'b0, 1'b1, o, a, b);
    @(posedge clk);
    wait_result(1'b0, er, ef, lat, tag, poke);
    drive(1'b0, 1'b0, 2'd0, 8'd0, 8'd0);
  endtask

  task automatic run_random(input bit w8, input int n);
    int         w   = w8 ? 8 : 4;
    int         lim = (1 << w) - 1;
    logic [1:0] o;
    longint     a, b, r;
    logic       f;
    int         lat;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      o = 2'($urandom_range(0, 3));
      a = longint'($urandom_range(0, lim));
      b = ($urandom_range(0, 7) == 0) ? 0 : longint'($urandom_range(0, lim));
      model(w, o, a, b, r, f, lat);
      drive(w8, 1'b1, o, 8'(a), 8'(b));
      @(posedge clk);
      wait_result(w8, r, f, lat, w8 ? "rnd8" : "rnd4",
                  (lat > 3) && ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 3) == 0) begin
        drive(w8, 1'b0, 2'd0, 8'd0, 8'd0);
        repeat ($urandom_range(1, 3)) begin
          @(negedge clk);
          check(w8 ? "rnd8_idle_done" : "rnd4_idle_done", longint'(obs_done(w8)), 0);
        end
      end
    end
    drive(w8, 1'b0, 2'd0, 8'd0, 8'd0);
  endtask

  initial begin
    #1;
    check("rst_busy", longint'(busy4), 0);
    check("rst_done", longint'(done4), 0);
    check("rst_result", longint'(result4), 0);
    check("rst_flag", longint'(flag4), 0);
    check("rst_result8", longint'(result8), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    dir4(2'd0, 8'd15, 8'd1, 64'h10, 1'b1, 1, "add15_1", 1'b0);
    dir4(2'd0, 8'd3,  8'd4, 64'h07, 1'b0, 1, "add3_4",  1'b0);
    dir4(2'd1, 8'd3,  8'd5, 64'h0E, 1'b1, 1, "sub3_5",  1'b0);
    dir4(2'd1, 8'd9,  8'd9, 64'h00, 1'b0, 1, "sub9_9",  1'b0);
    dir4(2'd2, 8'd15, 8'd15, 64'hE1, 1'b1, 5, "mul15_15", 1'b1);
    dir4(2'd2, 8'd3,  8'd5, 64'h0F, 1'b0, 5, "mul3_5",  1'b1);
    dir4(2'd3, 8'd13, 8'd4, 64'h13, 1'b0, 5, "div13_4", 1'b0);
    dir4(2'd3, 8'd9,  8'd0, 64'h9F, 1'b1, 1, "div9_0",  1'b0);

    // Abort a multiply with reset two cycles into the operation.
    drive(1'b0, 1'b1, 2'd2, 8'd7, 8'd7);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'd0, 8'd0, 8'd0);
    check("abort_busy_before", longint'(busy4), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", longint'(busy4), 0);
    check("abort_result", longint'(result4), 0);
    check("abort_flag", longint'(flag4), 0);
    check("abort_done", longint'(done4), 0);
    last_r4 = 0; last_f4 = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("abort_done_rst", longint'(done4), 0);
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("abort_no_done", longint'(done4), 0);
    end
    dir4(2'd0, 8'd2, 8'd2, 64'h04, 1'b0, 1, "add2_2", 1'b0);

    run_random(1'b0, 600);
    run_random(1'b1, 600);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule
`default_nettype wire
